// File: rtl/cmd_sequencer_if.sv
// Host push port plus sender handshake for cmd_sequencer.
// The master side feeds commands and the sender busy flag. The slave side is the sequencer.
interface cmd_sequencer_if #(
  parameter int AW = 3
);
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          flush;
  logic          full;
  logic [AW:0]   count;
  logic [7:0]    cmd_out;
  logic          str_out;
  logic          snd_busy;
  logic          seq_busy;
  logic          done;
  logic          err_range;
  logic          err_timeout;

  modport master (
    output wr_en, wr_data, flush, snd_busy,
    input  full, count, cmd_out, str_out, seq_busy, done, err_range, err_timeout
  );

  modport slave (
    input  wr_en, wr_data, flush, snd_busy,
    output full, count, cmd_out, str_out, seq_busy, done, err_range, err_timeout
  );
endinterface

// File: rtl/cmd_sequencer.sv
// Queues command indices and issues them one at a time to the UART string sender (str, busy up/down, gap).
// Pushes are dropped when full or out of range. A missing busy acknowledge sets a sticky error and the command is skipped.
module cmd_sequencer #(
  parameter int DEPTH       = 8,
  parameter int AW          = 3,
  parameter int MAX_CMD     = 15,
  parameter int GAP_CYCLES  = 5000,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic            clk,
  input  logic            rst,
  cmd_sequencer_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, GAP} state_t;

  localparam logic [27:0] GAP_T = 28'(GAP_CYCLES);
  localparam logic [27:0] ACK_T = 28'(ACK_TIMEOUT);

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [27:0]   timer;
  logic [7:0]    cmd_q;
  logic          str_q;
  logic          done_q;
  logic          err_range_q;
  logic          err_timeout_q;
  logic          full;
  logic          empty;
  logic          bad;
  logic          pop;
  logic          push;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign bad   = (bus.wr_data > 8'(MAX_CMD));
  // A pop frees the slot in the same cycle, so a push at full still lands.
  assign pop   = !bus.flush && (state == IDLE) && !empty && !bus.snd_busy;
  assign push  = !bus.flush && bus.wr_en && !bad && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      err_range_q <= 1'b0;
    end else begin
      err_range_q <= !bus.flush && bus.wr_en && bad;
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      timer         <= '0;
      cmd_q         <= '0;
      str_q         <= 1'b0;
      done_q        <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      str_q  <= 1'b0;
      done_q <= 1'b0;
      if (bus.flush) begin
        state         <= IDLE;
        timer         <= '0;
        err_timeout_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (pop) begin
              cmd_q <= mem[rd_ptr];
              str_q <= 1'b1;
              state <= ISSUE;
            end
          end
          ISSUE: begin
            timer <= ACK_T;
            state <= WAIT_ACK;
          end
          WAIT_ACK: begin
            if (bus.snd_busy) begin
              state <= WAIT_DONE;
            end else if (timer <= 28'd1) begin
              // Unacknowledged command is dropped, but the gap is still honoured.
              timer         <= GAP_T;
              err_timeout_q <= 1'b1;
              state         <= GAP;
            end else begin
              timer <= timer - 28'd1;
            end
          end
          WAIT_DONE: begin
            if (!bus.snd_busy) begin
              timer <= GAP_T;
              state <= GAP;
            end
          end
          GAP: begin
            if (timer <= 28'd1) begin
              timer  <= '0;
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              timer <= timer - 28'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.full        = full;
  assign bus.count       = count;
  assign bus.cmd_out     = cmd_q;
  assign bus.str_out     = str_q;
  assign bus.seq_busy    = !empty || (state != IDLE);
  assign bus.done        = done_q;
  assign bus.err_range   = err_range_q;
  assign bus.err_timeout = err_timeout_q;
endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: push vectors table, sender model, issue-order scoreboard, timing corner sequences.
module tb_cmd_sequencer;
  localparam int DEPTH = 8, AW = 3, MAX_CMD = 15, G = 40, A = 25, BUSY_LEN = 50;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cmd_sequencer_if #(.AW(AW)) bus();

  cmd_sequencer #(
    .DEPTH(DEPTH), .AW(AW), .MAX_CMD(MAX_CMD), .GAP_CYCLES(G), .ACK_TIMEOUT(A)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  logic force_busy = 1'b0;
  logic model_busy = 1'b0;
  bit sender_en = 1'b0;
  int str_cyc = -1;
  int last_str = -1;
  int fall_cyc = -1;
  logic prev_str = 1'b0;

  assign bus.snd_busy = force_busy | model_busy;

  typedef struct {
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        accept;
    logic [AW:0] count;
    logic        full;
    logic        err_range;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.seq_busy || model_busy) && n < budget) begin
      step();
      n++;
    end
    chk(name, (n < budget), 1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard / timing monitor
  always @(posedge clk) begin
    #1;
    if (rst) begin
      if (bus.str_out) begin
        chk("str_one_cycle", prev_str, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_str cmd_out=%0h required=no issue", bus.cmd_out);
        end else begin
          chk("issue_order", bus.cmd_out, exp_q.pop_front());
        end
        if (last_str >= 0) begin
          checks++;
          if (cyc - last_str < 3 + G) begin
            errors++;
            $display("FAIL str_spacing actual=%0d required>=%0d", cyc - last_str, 3 + G);
          end
        end
        last_str = cyc;
        str_cyc  = cyc;
      end
      prev_str = bus.str_out;
      if (bus.done && fall_cyc >= 0) begin
        chk("done_latency", cyc - fall_cyc, G + 1);
        fall_cyc = -1;
      end
    end
  end

  // Sender model: busy rises 2 cycles after str and holds BUSY_LEN cycles
  initial begin
    forever begin
      step();
      if (sender_en && bus.str_out) begin
        repeat (2) @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (BUSY_LEN) @(posedge clk);
        #1 model_busy = 1'b0;
        fall_cyc = cyc;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{1'b1, 8'h10, 1'b0, 4'd0, 1'b0, 1'b1};
    for (int i = 1; i <= 8; i++)
      vecs[i] = '{1'b1, 8'(i), 1'b1, 4'(i), (i == 8), 1'b0};
    vecs[9]  = '{1'b1, 8'h09, 1'b0, 4'd8, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 8'hFF, 1'b0, 4'd8, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 4'd8, 1'b1, 1'b0};

    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.flush = 1'b0;
    repeat (3) step();
    chk("rst_count", bus.count, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_cmd_out", bus.cmd_out, 0);
    chk("rst_str_out", bus.str_out, 0);
    chk("rst_seq_busy", bus.seq_busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err_range", bus.err_range, 0);
    chk("rst_err_timeout", bus.err_timeout, 0);
    rst = 1'b1;
    step();

    // Basic issue of a single command
    sender_en = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h03;
    exp_q.push_back(8'h03);
    step();
    bus.wr_en = 1'b0;
    chk("basic_count_after_push", bus.count, 1);
    wait_idle("basic_complete", 500);
    chk("basic_count_final", bus.count, 0);

    // Push table with the sender held busy so nothing issues
    force_busy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.wr_en = vecs[i].wr_en;
      bus.wr_data = vecs[i].wr_data;
      if (vecs[i].accept) exp_q.push_back(vecs[i].wr_data);
      step();
      chk($sformatf("vec%0d_count", i), bus.count, vecs[i].count);
      chk($sformatf("vec%0d_full", i), bus.full, vecs[i].full);
      chk($sformatf("vec%0d_err_range", i), bus.err_range, vecs[i].err_range);
    end
    bus.wr_en = 1'b0;
    chk("full_seq_busy", bus.seq_busy, 1);
    chk("full_no_str", bus.str_out, 0);

    // Push coinciding with the pop at full
    force_busy = 1'b0;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h0A;
    exp_q.push_back(8'h0A);
    step();
    bus.wr_en = 1'b0;
    chk("simul_count", bus.count, 8);
    chk("simul_full", bus.full, 1);
    chk("simul_str", bus.str_out, 1);
    wait_idle("queue_drain", 3000);
    chk("drain_count", bus.count, 0);
    chk("drain_full", bus.full, 0);

    // Ack timeout: sender ignores the first command
    sender_en = 1'b0;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h05;
    exp_q.push_back(8'h05);
    step();
    bus.wr_data = 8'h06;
    exp_q.push_back(8'h06);
    step();
    bus.wr_en = 1'b0;
    n = 0;
    while (!bus.err_timeout && n < 200) begin
      step();
      n++;
    end
    chk("timeout_seen", (n < 200), 1);
    chk("timeout_latency", cyc - str_cyc, A + 1);
    sender_en = 1'b1;
    repeat (5) step();
    chk("timeout_in_gap", bus.err_timeout, 1);
    wait_idle("after_timeout", 1000);
    chk("timeout_sticky", bus.err_timeout, 1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    last_str = -1;
    chk("flush_clears_timeout", bus.err_timeout, 0);

    // Flush during WAIT_DONE with 4 entries queued
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'h0B + 8'(i);
      if (i == 0) exp_q.push_back(8'h0B);
      step();
    end
    bus.wr_en = 1'b0;
    chk("pre_flush_count", bus.count, 4);
    n = 0;
    while (!model_busy && n < 20) begin
      step();
      n++;
    end
    chk("sender_busy_seen", (n < 20), 1);
    repeat (3) step();
    bus.flush = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h01;
    step();
    bus.flush = 1'b0;
    bus.wr_en = 1'b0;
    last_str = -1;
    chk("flush_count", bus.count, 0);
    chk("flush_seq_busy", bus.seq_busy, 0);
    chk("flush_str", bus.str_out, 0);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h07;
    exp_q.push_back(8'h07);
    step();
    bus.wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("no_issue_while_busy", bus.str_out, 0);
      step();
    end
    chk("held_count", bus.count, 1);
    wait_idle("after_flush", 1000);

    // Reset asserted while str_out is high
    sender_en = 1'b0;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h02;
    exp_q.push_back(8'h02);
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
    n = 0;
    while (!bus.str_out && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("issue_before_reset", bus.str_out, 1);
    rst = 1'b0;
    #1;
    chk("rstmid_str_out", bus.str_out, 0);
    chk("rstmid_cmd_out", bus.cmd_out, 0);
    chk("rstmid_count", bus.count, 0);
    chk("rstmid_full", bus.full, 0);
    chk("rstmid_seq_busy", bus.seq_busy, 0);
    chk("rstmid_done", bus.done, 0);
    chk("rstmid_err_range", bus.err_range, 0);
    chk("rstmid_err_timeout", bus.err_timeout, 0);
    step();
    rst = 1'b1;
    repeat (3) step();
    chk("post_reset_str", bus.str_out, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
